nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that streams operands through a single existing `CLA_4_bit` instance, one nibble per clock, least-significant nibble first. It sits directly upstream of the `CLA_4_bit` carry-lookahead stage: it feeds that stage nibble slices and a registered carry, then reassembles the sum. It trades latency for area in datapaths that already hold a 4-bit CLA.

## Interface
- `WIDTH`, default 16: operand and sum width. Must be a multiple of 4 and at least 8.
- `NIB`, derived as WIDTH/4: number of nibble passes. Not overridable.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only while `busy`=0.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: `sum`/`cout` are valid.
- `sum`  out  WIDTH  result; held until the next accepted `start`.
- `cout`  out  1  carry out of bit WIDTH-1; held like `sum`.

## Operation
- State machine:
  - IDLE: `start` → RUN. Latch `a`, `b`, `cin`; clear `sum`, `cout`, and the nibble index to 0.
  - RUN: each edge, add nibble[idx] of A and B with the carry register through `CLA_4_bit`.
    - Write the 4-bit result into sum[4·idx+3 : 4·idx].
    - Carry register ← CLA cout; idx ← idx+1.
    - The pass with idx = NIB−1 → DONE, and `cout` ← final CLA cout.
  - DONE: lasts one cycle, with `done`=1.
    - `start`=1 → accept a new operation exactly as from IDLE (→ RUN).
    - Otherwise → IDLE.
- `start` while `busy`=1 is ignored. It is not queued. Operand inputs may change freely while busy.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). No overflow flag; unsigned interpretation only.
- Sum nibbles not yet written read 0 during RUN. Only values in the `done` cycle and after are architecturally valid.
- Reset (asserted at any time, including mid-RUN):
  - State IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0; internal operand, carry and index registers = 0.
  - An in-flight operation is abandoned and no `done` is produced.
  - Deassertion needs no special sequencing. The first edge with `rst_n`=1 may accept `start`.

## Timing
- Let E be the edge accepting `start`. Then:
  - `busy` rises at E.
  - Nibble k is computed at edge E+1+k, for k = 0..NIB−1.
  - `busy` falls and `done` rises at edge E+NIB.
  - `done` falls at E+NIB+1, unless a new start was accepted there; `done` still falls in that case.
- Latency: NIB edges from acceptance to `done`. WIDTH=16 gives 4.
- Throughput: one operation per NIB+1 cycles, with back-to-back `start` in the DONE cycle.
- `done` and `busy` are never both 1.
- `sum`/`cout` are stable from E+NIB until the next accepting edge. At that edge they clear to 0.
- The CLA path is combinational between registers. No registered output depends combinationally on an input port.

## Structure
- Shared package `nibble_adder_pkg` holds:
  - the state enumeration (IDLE, RUN, DONE);
  - the nibble width constant (4);
  - a function computing the index width, ceil(log2(NIB)).
- Sub-module: one instance of the existing `CLA_4_bit` (ports `a`, `b`, `cin`, `cout`, `sum`). Do not write a new adder.
- Top module: FSM, operand shift/select, carry register, and result assembly.

## Test plan
- Reset then idle, WIDTH=16: hold `rst_n`=0 for 3 cycles → `busy`=0, `done`=0, `sum`=0x0000, `cout`=0; no `done` for 10 idle cycles.
- Basic add: a=0x000B, b=0x0001, cin=0, start at E → `done` at E+4 with sum=0x000C, cout=0. Then a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Also a=0x8000, b=0x8000, cin=1 → sum=0x0001, cout=1.
- Busy-ignore and back-to-back:
  - Pulse `start` with a=0x1111 during RUN → ignored; first result unchanged.
  - Assert `start` in the DONE cycle with a=0x0F0F, b=0x00F1 → second `done` 4 edges later with sum=0x1000.
- Mid-operation reset: assert `rst_n`=0 at E+2 of a 0xFFFF+0x0001 op → outputs 0 asynchronously and no `done`. A following 0x0002+0x0003 → sum=0x0005.
- Randomised check vs a+b+cin for 1000 ops, WIDTH=16 and WIDTH=32 (latency 8).

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, nibble width,
// and the index-width helper.
package nibble_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(nib)), never less than 1 so the index register always exists
  function automatic int unsigned idx_width(input int unsigned nib);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < nib) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/CLA_4_bit.sv
// Existing 4-bit carry-lookahead adder stage shared by the serial adder.
module CLA_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] sum
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead terms, no ripple between bit positions
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands LS-nibble first through one CLA_4_bit,
// one nibble per clock, and reassembles the sum.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = idx_width(NIB);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NIB_W-1:0]   cla_sum_c;
  logic               cla_cout_c;

  // Operands shift right each pass, so the CLA always sees bits [3:0]
  CLA_4_bit u_cla (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .cin  (carry_q),
    .cout (cla_cout_c),
    .sum  (cla_sum_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      // DONE accepts a new request exactly like IDLE
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = cla_sum_c;
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        carry_d = cla_cout_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIB - 1)) begin
          state_d = DONE;
          cout_d  = cla_cout_c;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: per-cycle arithmetic model for WIDTH=16, directed and
// random operations on WIDTH=16 and WIDTH=32 instances.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  logic        s_start, s_cin, s_busy, s_done, s_cout;
  logic [15:0] s_a, s_b, s_sum;
  logic        t_start, t_cin, t_busy, t_done, t_cout;
  logic [31:0] t_a, t_b, t_sum;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(t_start), .a(t_a), .b(t_b), .cin(t_cin),
    .busy(t_busy), .done(t_done), .sum(t_sum), .cout(t_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] low_mask(input int unsigned k);
    return 16'((32'd1 << (4 * k)) - 32'd1);
  endfunction

  // Model: full-width sum computed at acceptance, revealed one nibble per cycle
  logic        m_busy, m_done, m_cout;
  logic [15:0] m_sum;
  logic [16:0] m_full;
  int unsigned m_pass;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cout <= 1'b0;
      m_sum  <= '0;   m_full <= '0;   m_pass <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && s_start) begin
        m_busy <= 1'b1;
        m_pass <= 0;
        m_full <= 17'(s_a) + 17'(s_b) + 17'(s_cin);
        m_sum  <= '0;
        m_cout <= 1'b0;
      end else if (m_busy) begin
        if (m_pass == 3) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_sum  <= m_full[15:0];
          m_cout <= m_full[16];
        end else begin
          m_pass <= m_pass + 1;
          m_sum  <= m_full[15:0] & low_mask(m_pass + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy16", 64'(s_busy), 64'(m_busy));
      chk("done16", 64'(s_done), 64'(m_done));
      chk("sum16",  64'(s_sum),  64'(m_sum));
      chk("cout16", 64'(s_cout), 64'(m_cout));
    end
  end

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c);
    s_a = a; s_b = b; s_cin = c; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (!s_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!s_done) chk("timeout16", 64'(s_done), 64'd1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec);
    int lat;
    issue16(a, b, c);
    chk("busy_at_accept16", 64'(s_busy), 64'd1);
    wait16(lat);
    chk("latency16", 64'(lat), 64'd4);
    chk("result_sum16", 64'(s_sum), 64'(es));
    chk("result_cout16", 64'(s_cout), 64'(ec));
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [31:0] es, input logic ec);
    int lat;
    t_a = a; t_b = b; t_cin = c; t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk("busy_at_accept32", 64'(t_busy), 64'd1);
    lat = 0;
    while (!t_done && lat < 30) begin
      @(negedge clk);
      chk("busy_done_excl32", 64'(t_busy & t_done), 64'd0);
      lat++;
    end
    chk("latency32", 64'(lat), 64'd8);
    chk("result_sum32", 64'(t_sum), 64'(es));
    chk("result_cout32", 64'(t_cout), 64'(ec));
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic [31:0] xa, xb;
    logic        rc;
    logic [16:0] r17;
    logic [32:0] r33;

    rst_n = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
    t_start = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy16", 64'(s_busy), 64'd0);
    chk("rst_done16", 64'(s_done), 64'd0);
    chk("rst_sum16",  64'(s_sum),  64'd0);
    chk("rst_cout16", 64'(s_cout), 64'd0);
    chk("rst_busy32", 64'(t_busy), 64'd0);
    chk("rst_sum32",  64'(t_sum),  64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_no_done16", 64'(s_done), 64'd0);
    end

    op16(16'h000B, 16'h0001, 1'b0, 16'h000C, 1'b0);
    op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    op16(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    @(negedge clk);

    // Ignored start mid-RUN, then back-to-back request in the DONE cycle
    issue16(16'h1234, 16'h4321, 1'b1);
    s_a = 16'h1111; s_b = 16'h2222; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_a = 16'hDEAD;
    wait16(lat);
    chk("ignore_latency16", 64'(lat + 1), 64'd4);
    chk("ignore_sum16", 64'(s_sum), 64'h5556);
    issue16(16'h0F0F, 16'h00F1, 1'b0);
    chk("b2b_done_low16", 64'(s_done), 64'd0);
    chk("b2b_sum_clear16", 64'(s_sum), 64'd0);
    wait16(lat);
    chk("b2b_latency16", 64'(lat), 64'd4);
    chk("b2b_sum16", 64'(s_sum), 64'h1000);
    chk("b2b_cout16", 64'(s_cout), 64'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation
    issue16(16'hFFFF, 16'h0001, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy16", 64'(s_busy), 64'd0);
    chk("midrst_done16", 64'(s_done), 64'd0);
    chk("midrst_sum16",  64'(s_sum),  64'd0);
    chk("midrst_cout16", 64'(s_cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_done16", 64'(s_done), 64'd0);
    end
    op16(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 7 == 0) ra = 16'hFFFF;
      r17 = 17'(ra) + 17'(rb) + 17'(rc);
      op16(ra, rb, rc, r17[15:0], r17[16]);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    @(negedge clk);

    op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    op32(32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      xa = $urandom; xb = $urandom; rc = 1'($urandom);
      r33 = 33'(xa) + 33'(xb) + 33'(rc);
      op32(xa, xb, rc, r33[31:0], r33[32]);
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
